// File: rtl/channel_receiver.sv
// Hard-slices noisy samples, hunts SYNC_WORD, deframes 16-bit payload words; flywheel holds lock for MAX_MISS-1 bad syncs. RX_SYNC_ERRCNT_EN adds sync bit-error counting.
// Latency: data_valid one cycle after the edge accepting the last payload bit; no backpressure, idle cycles (sample_valid=0) freeze all state.
module channel_receiver #(
    parameter logic        [15:0] SYNC_WORD   = 16'hB5A3,
    parameter logic signed [15:0] THRESHOLD   = 16'sd0,
    parameter int unsigned        MAX_MISS    = 3,
    parameter int unsigned        FRAME_CNT_W = 16
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [15:0]            sample_in,
    input  logic                   sample_valid,
    output logic [15:0]            data_out,
    output logic                   data_valid,
    output logic                   locked,
    output logic                   sync_lost,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [15:0]            err_count
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC_CHECK} state_t;

    localparam logic [4:0] MAX_MISS_L = 5'(MAX_MISS);

    state_t                 state, state_nxt;
    logic [15:0]            sr, sr_nxt;
    logic [3:0]             bit_cnt, bit_cnt_nxt;
    logic [4:0]             fill_cnt, fill_cnt_nxt;
    logic [3:0]             miss_cnt, miss_cnt_nxt;
    logic [15:0]            data_out_nxt;
    logic                   data_valid_nxt, sync_lost_nxt;
    logic [FRAME_CNT_W-1:0] frame_count_nxt;
    logic                   bit_in;
    logic                   chk_done;

    assign bit_in   = $signed(sample_in) >= THRESHOLD;
    assign chk_done = sample_valid && (state == SYNC_CHECK) && (bit_cnt == 4'd15);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            fill_cnt    <= '0;
            miss_cnt    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            sync_lost   <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            fill_cnt    <= fill_cnt_nxt;
            miss_cnt    <= miss_cnt_nxt;
            data_out    <= data_out_nxt;
            data_valid  <= data_valid_nxt;
            sync_lost   <= sync_lost_nxt;
            locked      <= (state_nxt != HUNT);
            frame_count <= frame_count_nxt;
        end
    end

    // The single shift register doubles as the payload/sync assembler: after 16 bits in a state it holds exactly that word.
    always_comb begin
        state_nxt       = state;
        sr_nxt          = sr;
        bit_cnt_nxt     = bit_cnt;
        fill_cnt_nxt    = fill_cnt;
        miss_cnt_nxt    = miss_cnt;
        data_out_nxt    = data_out;
        data_valid_nxt  = 1'b0;
        sync_lost_nxt   = 1'b0;
        frame_count_nxt = frame_count;
        if (sample_valid) begin
            sr_nxt = {sr[14:0], bit_in};
            unique case (state)
                HUNT: begin
                    fill_cnt_nxt = (fill_cnt == 5'd16) ? fill_cnt : fill_cnt + 5'd1;
                    if (fill_cnt >= 5'd15 && sr_nxt == SYNC_WORD) begin
                        state_nxt    = PAYLOAD;
                        bit_cnt_nxt  = '0;
                        miss_cnt_nxt = '0;
                    end
                end
                PAYLOAD: begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        data_out_nxt    = sr_nxt;
                        data_valid_nxt  = 1'b1;
                        frame_count_nxt = frame_count + FRAME_CNT_W'(1);
                        state_nxt       = SYNC_CHECK;
                    end
                end
                SYNC_CHECK: begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        if (sr_nxt == SYNC_WORD) begin
                            miss_cnt_nxt = '0;
                            state_nxt    = PAYLOAD;
                        end else if (({1'b0, miss_cnt} + 5'd1) < MAX_MISS_L) begin
                            miss_cnt_nxt = miss_cnt + 4'd1;
                            state_nxt    = PAYLOAD;
                        end else begin
                            state_nxt     = HUNT;
                            sync_lost_nxt = 1'b1;
                            fill_cnt_nxt  = '0;
                            miss_cnt_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

`ifdef RX_SYNC_ERRCNT_EN
    logic [4:0]  err_bits;
    logic [16:0] err_sum;

    assign err_bits = 5'($countones(sr_nxt ^ SYNC_WORD));
    assign err_sum  = {1'b0, err_count} + {12'd0, err_bits};

    // Survives loss of lock so noise history accumulates across re-syncs.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            err_count <= '0;
        else if (chk_done)
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_channel_receiver.sv
// Randomized bench for channel_receiver with a word-level reference model and per-cycle output compare.
module tb_channel_receiver;

    localparam logic [15:0] SYNC = 16'hB5A3;
    localparam int          TH   = 100;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        locked;
    logic        sync_lost;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    channel_receiver #(
        .SYNC_WORD(SYNC), .THRESHOLD(16'sd100), .MAX_MISS(3), .FRAME_CNT_W(16)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .data_out(data_out), .data_valid(data_valid), .locked(locked), .sync_lost(sync_lost),
        .frame_count(frame_count), .err_count(err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: bit history window, hunt sample count, and frame/miss bookkeeping.
    int          m_hunt_n = 0;
    int          m_nb = 0;
    int          m_miss = 0;
    bit          m_lock = 0, m_chk = 0, m_dv = 0, m_sl = 0;
    logic [15:0] m_win = '0, m_dout = '0, m_frames = '0, m_err = '0;

    logic [15:0] e_dout = '0, e_frames = '0, e_err = '0;
    bit          e_dv = 0, e_sl = 0, e_lock = 0;
    bit          armed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [15:0] s, input bit v, input bit r);
        bit b;
        int t;
        m_dv = 0;
        m_sl = 0;
        if (r) begin
            m_hunt_n = 0; m_nb = 0; m_miss = 0; m_lock = 0; m_chk = 0;
            m_win = '0; m_dout = '0; m_frames = '0; m_err = '0;
        end else if (v) begin
            b = (int'($signed(s)) >= TH);
            m_win = {m_win[14:0], b};
            if (!m_lock) begin
                m_hunt_n++;
                if (m_hunt_n >= 16 && m_win == SYNC) begin
                    m_lock = 1; m_chk = 0; m_nb = 0; m_miss = 0;
                end
            end else begin
                m_nb++;
                if (m_nb == 16) begin
                    m_nb = 0;
                    if (!m_chk) begin
                        m_dout = m_win;
                        m_dv = 1;
                        m_frames++;
                        m_chk = 1;
                    end else begin
                        t = int'(m_err) + $countones(m_win ^ SYNC);
`ifdef RX_SYNC_ERRCNT_EN
                        m_err = (t > 65535) ? 16'hFFFF : t[15:0];
`endif
                        m_chk = 0;
                        if (m_win == SYNC) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss >= 3) begin
                                m_lock = 0; m_sl = 1; m_hunt_n = 0; m_miss = 0;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [15:0] s, input bit v, input bit r);
        @(negedge CLOCK_50);
        sample_in = s;
        sample_valid = v;
        reset = r;
        model_step(s, v, r);
        @(posedge CLOCK_50);
        #1;
        e_dout = m_dout; e_dv = m_dv; e_lock = m_lock;
        e_sl = m_sl; e_frames = m_frames; e_err = m_err;
        armed = 1;
    endtask

    // mode 0: +/-1000, mode 1: slicer boundary values, mode 2: random magnitude
    function automatic logic [15:0] enc(input bit b, input int mode);
        bit r;
        r = bit'($urandom_range(0, 1));
        if (mode == 0) return b ? 16'sd1000 : -16'sd1000;
        if (mode == 1) return b ? (r ? 16'sd100 : 16'sd32767) : (r ? 16'sd99 : -16'sd32768);
        return b ? 16'(100 + int'($urandom_range(0, 32667))) : 16'(99 - int'($urandom_range(0, 32867)));
    endfunction

    task automatic send_bit(input bit b, input int mode, input bit gap);
        if (gap) step(16'($urandom), 0, 0);
        step(enc(b, mode), 1, 0);
    endtask

    task automatic send_word(input logic [15:0] w, input int mode, input bit gap);
        for (int i = 15; i >= 0; i--) send_bit(w[i], mode, gap);
    endtask

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (armed) begin
                check("data_out", data_out, e_dout);
                check("data_valid", data_valid, e_dv);
                check("locked", locked, e_lock);
                check("sync_lost", sync_lost, e_sl);
                check("frame_count", frame_count, e_frames);
                check("err_count", err_count, e_err);
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic [15:0] p;
        int junk;

        step(16'h0, 1, 1);
        step(16'h0, 1, 1);
        check("rst_locked", locked, 0);
        check("rst_frames", frame_count, 0);
        check("rst_dout", data_out, 0);

        // 1: sync then payload 1234
        w = SYNC;
        for (int i = 15; i >= 1; i--) send_bit(w[i], 0, 0);
        check("t1_not_early", locked, 0);
        send_bit(w[0], 0, 0);
        check("t1_locked", locked, 1);
        send_word(16'h1234, 0, 0);
        check("t1_dv", data_valid, 1);
        check("t1_dout", data_out, 16'h1234);
        check("t1_model_dout", e_dout, 16'h1234);
        check("t1_frames", frame_count, 1);

        // 2: gapped sync + ABCD
        send_word(SYNC, 0, 1);
        send_word(16'hABCD, 0, 1);
        check("t2_dv", data_valid, 1);
        check("t2_dout", data_out, 16'hABCD);
        check("t2_frames", frame_count, 2);
        step(16'h0, 0, 0);
        check("t2_hold", data_out, 16'hABCD);

        // 3: three single-bit-error syncs drop lock on the third
        send_word(16'hB5A2, 0, 0);
        send_word(16'h0F0F, 0, 0);
        check("t3_fly1", data_out, 16'h0F0F);
        send_word(16'hB5A2, 0, 0);
        send_word(16'hF00D, 0, 0);
        check("t3_fly2", data_out, 16'hF00D);
        check("t3_locked_still", locked, 1);
        send_word(16'hB5A2, 0, 0);
        check("t3_sync_lost", sync_lost, 1);
        check("t3_locked", locked, 0);
        check("t3_frames", frame_count, 4);
`ifdef RX_SYNC_ERRCNT_EN
        check("t3_err", err_count, 3);
`else
        check("t3_err", err_count, 0);
`endif

        // 4: slicer boundary samples
        send_word(SYNC, 1, 0);
        check("t4_locked", locked, 1);
        send_word(16'h5A0F, 1, 0);
        check("t4_dout", data_out, 16'h5A0F);

        // 5: reset mid-payload with a valid sample on the same edge
        send_word(SYNC, 0, 0);
        p = 16'hC3C3;
        for (int i = 15; i >= 8; i--) send_bit(p[i], 0, 0);
        step(enc(p[7], 0), 1, 1);
        check("t5_locked", locked, 0);
        check("t5_frames", frame_count, 0);
        check("t5_dv", data_valid, 0);
        for (int i = 6; i >= 0; i--) send_bit(p[i], 0, 0);
        send_word(16'h1234, 0, 0);
        check("t5_no_lock", locked, 0);
        send_word(SYNC, 0, 0);
        send_word(16'h0F0F, 0, 0);
        check("t5_relock_dv", data_valid, 1);
        check("t5_relock_frames", frame_count, 1);

        // 6: 15-bit prefix plus wrong bit, then full sync
        step(16'h0, 0, 1);
        w = SYNC;
        for (int i = 15; i >= 1; i--) send_bit(w[i], 0, 0);
        send_bit(~w[0], 0, 0);
        check("t6_bad_bit", locked, 0);
        for (int i = 15; i >= 1; i--) send_bit(w[i], 0, 0);
        check("t6_not_early", locked, 0);
        send_bit(w[0], 0, 0);
        check("t6_locked", locked, 1);

        // Random frames: noisy syncs, random payloads, gaps and slips
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                junk = int'($urandom_range(1, 5));
                for (int j = 0; j < junk; j++) send_bit(bit'($urandom_range(0, 1)), 2, 0);
            end
            w = SYNC;
            if ($urandom_range(0, 3) == 0) w = w ^ 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) w = 16'($urandom);
            p = 16'($urandom);
            for (int i = 15; i >= 0; i--) send_bit(w[i], 2, ($urandom_range(0, 5) == 0));
            for (int i = 15; i >= 0; i--) send_bit(p[i], 2, ($urandom_range(0, 5) == 0));
        end

        step(16'h0, 0, 0);
        step(16'h0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
